// File: rtl/piezo_pkg.sv
// Shared types, widths and the note half-period table for the piezo tone scheduler.
package piezo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  localparam int unsigned NOTE_W = 4;
  localparam int unsigned HP_W   = 11;
  localparam int unsigned CNT_W  = 17;

  localparam logic [NOTE_W-1:0] NOTE_REST = 4'd15;

  localparam int unsigned BEAT_CYC_DEF = 62500;
  localparam int unsigned GAP_CYC_DEF  = 20000;

  // Codes 0..7 are C4..C5; codes 8..14 reuse the same entries one octave up.
  function automatic logic [HP_W-1:0] note_hp(input logic [NOTE_W-1:0] code);
    logic [HP_W-1:0] base;
    case (code[2:0])
      3'd0:    base = 11'd1910;
      3'd1:    base = 11'd1702;
      3'd2:    base = 11'd1516;
      3'd3:    base = 11'd1431;
      3'd4:    base = 11'd1275;
      3'd5:    base = 11'd1136;
      3'd6:    base = 11'd1012;
      default: base = 11'd955;
    endcase
    return code[3] ? (base >> 1) : base;
  endfunction

endpackage

// File: rtl/piezo_tone_gen.sv
// Square-wave generator: toggles SONG each time the counter reaches HP.
module piezo_tone_gen
  import piezo_pkg::*;
(
  input  logic            CLK_1MHZ,
  input  logic            RESET,
  input  logic            EN,
  input  logic            CLR,
  input  logic [HP_W-1:0] HP,
  output logic            SONG
);

  logic [HP_W-1:0] cnt;

  // Disabled or cleared means silent with the phase restarted.
  always_ff @(posedge CLK_1MHZ or posedge RESET) begin
    if (RESET) begin
      cnt  <= '0;
      SONG <= 1'b0;
    end else if (CLR || !EN) begin
      cnt  <= '0;
      SONG <= 1'b0;
    end else if (cnt == HP) begin
      cnt  <= '0;
      SONG <= ~SONG;
    end else begin
      cnt <= cnt + HP_W'(1);
    end
  end

endmodule

// File: rtl/piezo_tone_scheduler.sv
// Fixed-priority sharing of one piezo between N_REQ requesters: one note plus a gap per grant.
// Optional preemption by a higher-priority request when PIEZO_PREEMPT_EN is defined.
module piezo_tone_scheduler
  import piezo_pkg::*;
#(
  parameter int unsigned N_REQ    = 3,
  parameter int unsigned BEAT_CYC = BEAT_CYC_DEF,
  parameter int unsigned GAP_CYC  = GAP_CYC_DEF
) (
  input  logic                    CLK_1MHZ,
  input  logic                    RESET,
  input  logic [N_REQ-1:0]        REQ,
  input  logic [NOTE_W*N_REQ-1:0] NOTE,
  input  logic [NOTE_W*N_REQ-1:0] LEN,
  output logic                    SONG,
  output logic [N_REQ-1:0]        GNT,
  output logic [N_REQ-1:0]        DONE,
  output logic                    ABORT,
  output logic                    BUSY
);

  state_e              state_q, state_d;
  logic [NOTE_W-1:0]   note_q, len_q, beat_idx;
  logic [CNT_W-1:0]    beat_cnt, gap_cnt;
  logic [N_REQ-1:0]    req_eff, pick, gnt_d, done_d;
  logic [NOTE_W-1:0]   sel_note, sel_len;
  logic                grant, preempt, play_last, gap_last, abort_d, busy_d, tone_en;

  // The requester that just finished sits out one arbitration round.
  assign req_eff = REQ & ~DONE;
  assign pick    = req_eff & (~req_eff + N_REQ'(1));
  assign grant   = (state_q == ST_IDLE) && (|req_eff);

  always_comb begin
    sel_note = '0;
    sel_len  = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (pick[i]) begin
        sel_note = NOTE[NOTE_W*i +: NOTE_W];
        sel_len  = LEN[NOTE_W*i +: NOTE_W];
      end
    end
  end

`ifdef PIEZO_PREEMPT_EN
  assign preempt = (state_q != ST_IDLE) && (|(REQ & (GNT - N_REQ'(1))));
`else
  assign preempt = 1'b0;
`endif

  // A length of 0 wraps to 15 here, which plays 16 beats.
  assign play_last = (beat_cnt == CNT_W'(BEAT_CYC - 1)) && (beat_idx == len_q - NOTE_W'(1));
  assign gap_last  = (gap_cnt == CNT_W'(GAP_CYC - 1));

  always_ff @(posedge CLK_1MHZ or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      GNT     <= '0;
      DONE    <= '0;
      ABORT   <= 1'b0;
      BUSY    <= 1'b0;
    end else begin
      state_q <= state_d;
      GNT     <= gnt_d;
      DONE    <= done_d;
      ABORT   <= abort_d;
      BUSY    <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (grant) state_d = ST_PLAY;
      ST_PLAY: begin
        if (preempt)        state_d = ST_IDLE;
        else if (play_last) state_d = ST_GAP;
      end
      ST_GAP:  if (preempt || gap_last) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    gnt_d   = GNT;
    done_d  = '0;
    abort_d = 1'b0;
    busy_d  = (state_d != ST_IDLE);
    if (grant) begin
      gnt_d = pick;
    end else if ((state_q != ST_IDLE) && (state_d == ST_IDLE)) begin
      gnt_d   = '0;
      done_d  = GNT;
      abort_d = preempt;
    end
  end

  // Note latch plus beat and gap counters.
  always_ff @(posedge CLK_1MHZ or posedge RESET) begin
    if (RESET) begin
      note_q   <= '0;
      len_q    <= '0;
      beat_cnt <= '0;
      beat_idx <= '0;
      gap_cnt  <= '0;
    end else if (grant) begin
      note_q   <= sel_note;
      len_q    <= sel_len;
      beat_cnt <= '0;
      beat_idx <= '0;
      gap_cnt  <= '0;
    end else if (state_q == ST_PLAY) begin
      if (beat_cnt == CNT_W'(BEAT_CYC - 1)) begin
        beat_cnt <= '0;
        beat_idx <= beat_idx + NOTE_W'(1);
      end else begin
        beat_cnt <= beat_cnt + CNT_W'(1);
      end
    end else if (state_q == ST_GAP) begin
      gap_cnt <= gap_cnt + CNT_W'(1);
    end
  end

  // Tone runs only while the next cycle is still PLAY, so SONG is already low on leaving it.
  assign tone_en = (state_q == ST_PLAY) && (state_d == ST_PLAY) && (note_q != NOTE_REST);

  piezo_tone_gen u_tone (
    .CLK_1MHZ (CLK_1MHZ),
    .RESET    (RESET),
    .EN       (tone_en),
    .CLR      (grant),
    .HP       (note_hp(note_q)),
    .SONG     (SONG)
  );

endmodule
